// File: rtl/vector_rev_pkg.sv
// Shared types and helpers for the vector-reverse link (state encoding, counter width, parity).
// Latency: n/a (package). Backpressure: n/a.
// Parity helper matches the transmit side: even parity over the data bits.
package vector_rev_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    localparam int PAR_MAX_W = 64;

    // cnt must reach MSB itself (parity slot), hence MSB+1 values.
    function automatic int cnt_width(input int msb);
        return $clog2(msb + 1);
    endfunction

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/vector_unreverse_rx_shifter.sv
// Indexed bit-write register: serial bit k lands in word[k]; cnt tracks the next index.
// Latency: one cycle from write enable to updated word/cnt.
// Backpressure: none; the controlling FSM gates wr_en.
module rx_shifter
    import vector_rev_pkg::*;
#(
    parameter int MSB = 5,
    parameter int CW  = cnt_width(MSB)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           wr_en,
    input  logic           first,
    input  logic           bit_in,
    output logic [MSB-1:0] word,
    output logic [CW-1:0]  cnt
);

    logic [MSB-1:0] word_q, word_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (wr_en && first) begin
            word_d    = '0;
            word_d[0] = bit_in;
            cnt_d     = CW'(1);
        end else if (wr_en) begin
            for (int i = 0; i < MSB; i++) begin
                if (cnt_q == CW'(i)) begin
                    word_d[i] = bit_in;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/vector_unreverse_rx.sv
// Rebuilds an MSB-bit word from an LSB-first serial stream; optional even parity via VECTOR_UNREVERSE_RX_PARITY_EN.
// Latency: out_valid visible the cycle after the last sampled bit (MSB bits, MSB+1 with parity).
// Backpressure: word held in HOLD until out_ready; bits arriving meanwhile are dropped and flagged by overrun.
module vector_unreverse_rx
    import vector_rev_pkg::*;
#(
    parameter int MSB = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sin,
    input  logic           sin_valid,
    output logic [MSB-1:0] out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           overrun,
    output logic           frame_err
`ifdef VECTOR_UNREVERSE_RX_PARITY_EN
    ,
    output logic           parity_err
`endif
);

    localparam int CW = cnt_width(MSB);

`ifdef VECTOR_UNREVERSE_RX_PARITY_EN
    localparam logic [CW-1:0] PAR_IDX   = CW'(MSB);
    localparam state_t        START_NXT = ST_SHIFT;
`else
    localparam logic [CW-1:0] LAST_IDX  = CW'(MSB - 1);
    // A one-bit frame is complete as soon as its start bit is sampled.
    localparam state_t        START_NXT = (MSB == 1) ? ST_HOLD : ST_SHIFT;
`endif

    state_t         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic           frame_err_q, frame_err_d;
    logic           wr_en, first, clr;
    logic [MSB-1:0] word;
    logic [CW-1:0]  cnt;
`ifdef VECTOR_UNREVERSE_RX_PARITY_EN
    logic           parity_err_q, parity_err_d;
`endif

    rx_shifter #(
        .MSB (MSB),
        .CW  (CW)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .wr_en  (wr_en),
        .first  (first),
        .bit_in (sin),
        .word   (word),
        .cnt    (cnt)
    );

    always_comb begin
        state_d     = state_q;
        wr_en       = 1'b0;
        first       = 1'b0;
        clr         = 1'b0;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef VECTOR_UNREVERSE_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sin_valid && start) begin
                    wr_en   = 1'b1;
                    first   = 1'b1;
                    state_d = START_NXT;
                end
            end
            ST_SHIFT: begin
                if (sin_valid) begin
                    if (start) begin
                        frame_err_d = 1'b1;
                        wr_en       = 1'b1;
                        first       = 1'b1;
                        state_d     = START_NXT;
                    end
`ifdef VECTOR_UNREVERSE_RX_PARITY_EN
                    else if (cnt == PAR_IDX) begin
                        if (sin == even_parity(PAR_MAX_W'(word))) begin
                            state_d = ST_HOLD;
                        end else begin
                            parity_err_d = 1'b1;
                            clr          = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        wr_en = 1'b1;
                    end
`else
                    else begin
                        wr_en = 1'b1;
                        if (cnt == LAST_IDX) begin
                            state_d = ST_HOLD;
                        end
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    // Accept and, if a start bit coincides, open the next frame without a bubble.
                    if (sin_valid && start) begin
                        wr_en   = 1'b1;
                        first   = 1'b1;
                        state_d = START_NXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (sin_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef VECTOR_UNREVERSE_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign out       = word;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
